// File: rtl/top.sv
// Embedded-system model: registered ALU, synchronous data memory, UART transmit
// holding/busy model and periodic timer sharing one clock and async reset.
module top #(
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TIMER_PERIOD = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_input1,
    input  logic [31:0] cpu_input2,
    input  logic [3:0]  cpu_operation,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_data_in,
    input  logic        memory_write_enable,
    input  logic [7:0]  uart_data_in,
    input  logic        uart_tx_enable,
    input  logic        timer_enable,
    output logic [31:0] cpu_result,
    output logic [31:0] memory_data_out,
    output logic [7:0]  uart_data_out,
    output logic        uart_tx_busy,
    output logic        timer_trigger,
    output logic        zero_flag
);

    localparam int unsigned AW           = $clog2(MEM_DEPTH);
    localparam int unsigned FRAME_CYCLES = 10 * CLKS_PER_BIT;
    localparam int unsigned FW           = $clog2(FRAME_CYCLES);
    localparam int unsigned TW           = $clog2(TIMER_PERIOD);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;

    typedef enum logic {
        UART_IDLE = 1'b0,
        UART_BUSY = 1'b1
    } uart_state_e;

    logic [31:0]   cpu_result_q, cpu_result_d;
    logic [31:0]   mem_q [MEM_DEPTH];
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    uart_state_e   uart_state_q, uart_state_d;
    logic [FW-1:0] uart_cnt_q, uart_cnt_d;
    logic [7:0]    uart_data_q, uart_data_d;
    logic [TW-1:0] tmr_cnt_q, tmr_cnt_d;
    logic          tmr_trig_q, tmr_trig_d;
    logic          unused_addr_hi;

    // ALU next result; undefined opcodes produce zero
    always_comb begin
        cpu_result_d = '0;
        case (cpu_operation)
            OP_ADD:  cpu_result_d = cpu_input1 + cpu_input2;
            OP_SUB:  cpu_result_d = cpu_input1 - cpu_input2;
            OP_AND:  cpu_result_d = cpu_input1 & cpu_input2;
            OP_OR:   cpu_result_d = cpu_input1 | cpu_input2;
            OP_XOR:  cpu_result_d = cpu_input1 ^ cpu_input2;
            OP_SLL:  cpu_result_d = cpu_input1 << cpu_input2[4:0];
            OP_SRL:  cpu_result_d = cpu_input1 >> cpu_input2[4:0];
            OP_SLT:  cpu_result_d = ($signed(cpu_input1) < $signed(cpu_input2)) ? 32'd1 : 32'd0;
            default: cpu_result_d = '0;
        endcase
    end

    // Upper address bits wrap onto the array
    assign mem_addr       = memory_address[AW-1:0];
    assign unused_addr_hi = ^memory_address[31:AW];

    always_ff @(posedge clk) begin
        if (memory_write_enable) begin
            mem_q[mem_addr] <= memory_data_in;
        end
    end

    // Write-first read port
    assign mem_rdata_d = memory_write_enable ? memory_data_in : mem_q[mem_addr];

    // UART: accept only when idle, then stay busy for one full frame
    always_comb begin
        uart_state_d = uart_state_q;
        uart_cnt_d   = uart_cnt_q;
        uart_data_d  = uart_data_q;
        case (uart_state_q)
            UART_IDLE: begin
                if (uart_tx_enable) begin
                    uart_state_d = UART_BUSY;
                    uart_cnt_d   = '0;
                    uart_data_d  = uart_data_in;
                end
            end
            UART_BUSY: begin
                if (uart_cnt_q == FW'(FRAME_CYCLES - 1)) begin
                    uart_state_d = UART_IDLE;
                    uart_cnt_d   = '0;
                end else begin
                    uart_cnt_d = uart_cnt_q + FW'(1);
                end
            end
        endcase
    end

    // Timer: wrap and pulse at end of period, hold while disabled
    always_comb begin
        tmr_cnt_d  = tmr_cnt_q;
        tmr_trig_d = 1'b0;
        if (timer_enable) begin
            if (tmr_cnt_q == TW'(TIMER_PERIOD - 1)) begin
                tmr_cnt_d  = '0;
                tmr_trig_d = 1'b1;
            end else begin
                tmr_cnt_d = tmr_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_result_q <= '0;
            mem_rdata_q  <= '0;
            uart_state_q <= UART_IDLE;
            uart_cnt_q   <= '0;
            uart_data_q  <= '0;
            tmr_cnt_q    <= '0;
            tmr_trig_q   <= 1'b0;
        end else begin
            cpu_result_q <= cpu_result_d;
            mem_rdata_q  <= mem_rdata_d;
            uart_state_q <= uart_state_d;
            uart_cnt_q   <= uart_cnt_d;
            uart_data_q  <= uart_data_d;
            tmr_cnt_q    <= tmr_cnt_d;
            tmr_trig_q   <= tmr_trig_d;
        end
    end

    assign cpu_result      = cpu_result_q;
    assign zero_flag       = (cpu_result_q == '0);
    assign memory_data_out = mem_rdata_q;
    assign uart_data_out   = uart_data_q;
    assign uart_tx_busy    = (uart_state_q == UART_BUSY);
    assign timer_trigger   = tmr_trig_q;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: per-edge reference model feeds an expected queue,
// a monitor pops and compares; directed phases add fixed-value checks.
module tb_top;

    localparam int PERIOD = 100;
    localparam int FRAME  = 160;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_input1 = '0;
    logic [31:0] cpu_input2 = '0;
    logic [3:0]  cpu_operation = '0;
    logic [31:0] memory_address = '0;
    logic [31:0] memory_data_in = '0;
    logic        memory_write_enable = 1'b0;
    logic [7:0]  uart_data_in = '0;
    logic        uart_tx_enable = 1'b0;
    logic        timer_enable = 1'b0;
    logic [31:0] cpu_result;
    logic [31:0] memory_data_out;
    logic [7:0]  uart_data_out;
    logic        uart_tx_busy;
    logic        timer_trigger;
    logic        zero_flag;

    always #5 clk = ~clk;

    top dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_input1          (cpu_input1),
        .cpu_input2          (cpu_input2),
        .cpu_operation       (cpu_operation),
        .memory_address      (memory_address),
        .memory_data_in      (memory_data_in),
        .memory_write_enable (memory_write_enable),
        .uart_data_in        (uart_data_in),
        .uart_tx_enable      (uart_tx_enable),
        .timer_enable        (timer_enable),
        .cpu_result          (cpu_result),
        .memory_data_out     (memory_data_out),
        .uart_data_out       (uart_data_out),
        .uart_tx_busy        (uart_tx_busy),
        .timer_trigger       (timer_trigger),
        .zero_flag           (zero_flag)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        zf;
        logic [31:0] mem;
        logic        mchk;
        logic [7:0]  uout;
        logic        busy;
        logic        trig;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_mem [256];
    bit          ref_valid [256];
    int          ref_rem = 0;
    int          ref_en_cnt = 0;
    int          ref_idx;
    exp_t        ref_st = '0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: frame as a remaining-cycle budget, timer as count of enabled edges
    always @(posedge clk) begin
        ref_idx = int'(memory_address[7:0]);
        if (!reset) begin
            ref_st      = '0;
            ref_st.zf   = 1'b1;
            ref_st.mchk = 1'b1;
            ref_rem     = 0;
            ref_en_cnt  = 0;
        end else begin
            ref_st.res = alu_ref(cpu_input1, cpu_input2, cpu_operation);
            ref_st.zf  = (ref_st.res == 32'd0);
            if (memory_write_enable) begin
                ref_mem[ref_idx]   = memory_data_in;
                ref_valid[ref_idx] = 1'b1;
            end
            ref_st.mem  = ref_mem[ref_idx];
            ref_st.mchk = ref_valid[ref_idx];
            if (ref_rem == 0 && uart_tx_enable) begin
                ref_st.uout = uart_data_in;
                ref_rem     = FRAME;
            end else if (ref_rem > 0) begin
                ref_rem--;
            end
            ref_st.busy = (ref_rem > 0);
            if (timer_enable) begin
                ref_en_cnt++;
                ref_st.trig = (ref_en_cnt % PERIOD == 0);
            end else begin
                ref_st.trig = 1'b0;
            end
        end
        exp_q.push_back(ref_st);
    end

    // Monitor: every edge presents a full output set
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected entry queued");
        end else begin
            mon_e = exp_q.pop_front();
            check("sb_cpu_result", cpu_result, mon_e.res);
            check("sb_zero_flag", 32'(zero_flag), 32'(mon_e.zf));
            if (mon_e.mchk) check("sb_mem_out", memory_data_out, mon_e.mem);
            check("sb_uart_out", 32'(uart_data_out), 32'(mon_e.uout));
            check("sb_uart_busy", 32'(uart_tx_busy), 32'(mon_e.busy));
            check("sb_timer_trig", 32'(timer_trigger), 32'(mon_e.trig));
        end
    end

    task automatic edge_wait();
        @(posedge clk);
        #2;
    endtask

    task automatic alu_step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        cpu_input1    = a;
        cpu_input2    = b;
        cpu_operation = op;
        edge_wait();
    endtask

    task automatic mem_step(input logic [31:0] addr, input logic [31:0] data, input logic we);
        @(negedge clk);
        memory_address      = addr;
        memory_data_in      = data;
        memory_write_enable = we;
        edge_wait();
    endtask

    task automatic count_to_trigger(input int off_lo, input int off_hi, output int n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            timer_enable = !(k >= off_lo && k < off_hi);
            edge_wait();
            k++;
        end while (!timer_trigger && k < 500);
        n = k;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        alu_step(32'd6, 32'd9, 4'd0);
        check("alu_add", cpu_result, 32'd15);
        check("alu_add_zf", 32'(zero_flag), 32'd0);
        alu_step(32'd6, 32'd9, 4'd1);
        check("alu_sub_neg", cpu_result, 32'hFFFF_FFFD);
        alu_step(32'd5, 32'd5, 4'd1);
        check("alu_sub_zero", cpu_result, 32'd0);
        check("alu_sub_zero_zf", 32'(zero_flag), 32'd1);
        alu_step(32'd5, 32'd5, 4'd12);
        check("alu_op12", cpu_result, 32'd0);
        alu_step(32'hFFFF_FFFD, 32'd2, 4'd7);
        check("alu_slt_signed", cpu_result, 32'd1);

        mem_step(32'd3, 32'd90, 1'b1);
        check("mem_write_first", memory_data_out, 32'd90);
        mem_step(32'd3, 32'd0, 1'b0);
        check("mem_read", memory_data_out, 32'd90);
        mem_step(32'h103, 32'd7, 1'b1);
        check("mem_write_wrap", memory_data_out, 32'd7);
        mem_step(32'd3, 32'd0, 1'b0);
        check("mem_read_wrap", memory_data_out, 32'd7);

        @(negedge clk);
        uart_data_in   = 8'h2D;
        uart_tx_enable = 1'b1;
        edge_wait();
        uart_tx_enable = 1'b0;
        check("uart_latch", 32'(uart_data_out), 32'h2D);
        check("uart_busy_start", 32'(uart_tx_busy), 32'd1);
        n = 0;
        while (uart_tx_busy && n < 400) begin
            n++;
            @(negedge clk);
            if (n == 50) begin
                uart_tx_enable = 1'b1;
                uart_data_in   = 8'h55;
            end else begin
                uart_tx_enable = 1'b0;
            end
            edge_wait();
        end
        check("uart_busy_len", n, FRAME);
        check("uart_ignore_busy", 32'(uart_data_out), 32'h2D);

        count_to_trigger(0, 0, n);
        check("timer_first", n, PERIOD);
        count_to_trigger(0, 0, n);
        check("timer_period", n, PERIOD);
        count_to_trigger(30, 40, n);
        check("timer_paused", n, PERIOD + 10);

        @(negedge clk);
        cpu_input1     = 32'd1;
        cpu_input2     = 32'd2;
        cpu_operation  = 4'd0;
        memory_address = 32'd3;
        uart_data_in   = 8'hA5;
        uart_tx_enable = 1'b1;
        timer_enable   = 1'b1;
        edge_wait();
        uart_tx_enable = 1'b0;
        repeat (40) edge_wait();
        #1;
        reset = 1'b0;
        #1;
        check("rst_cpu_result", cpu_result, 32'd0);
        check("rst_zero_flag", 32'(zero_flag), 32'd1);
        check("rst_mem_out", memory_data_out, 32'd0);
        check("rst_uart_out", 32'(uart_data_out), 32'd0);
        check("rst_uart_busy", 32'(uart_tx_busy), 32'd0);
        check("rst_timer_trig", 32'(timer_trigger), 32'd0);
        repeat (3) @(negedge clk);
        reset          = 1'b1;
        uart_data_in   = 8'h3C;
        uart_tx_enable = 1'b1;
        edge_wait();
        uart_tx_enable = 1'b0;
        check("rst_new_tx", 32'(uart_data_out), 32'h3C);
        check("rst_new_busy", 32'(uart_tx_busy), 32'd1);
        count_to_trigger(0, 0, n);
        check("timer_after_reset", n, PERIOD - 1);

        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            reset               = 1'b0;
            memory_write_enable = 1'b0;
            uart_tx_enable      = 1'b0;
            #1;
            check("rnd_rst_busy", 32'(uart_tx_busy), 32'd0);
            check("rnd_rst_result", cpu_result, 32'd0);
            repeat (10) @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < 300; c++) begin
                cpu_input1          = $urandom;
                cpu_input2          = ($urandom_range(0, 3) == 0) ? cpu_input1 : $urandom;
                cpu_operation       = 4'($urandom_range(0, 15));
                memory_address      = {24'($urandom), 4'h0, 4'($urandom_range(0, 15))};
                memory_data_in      = $urandom;
                memory_write_enable = ($urandom_range(0, 1) == 1);
                uart_data_in        = 8'($urandom);
                uart_tx_enable      = (it % 2 == 1) ? 1'b1 : ($urandom_range(0, 15) == 0);
                timer_enable        = ($urandom_range(0, 9) != 0);
                @(negedge clk);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
